// File: rtl/balance_pkg.sv
// Shared types and constants for the balance update controller.
// Imported by the controller and its BCD converter.
package balance_pkg;
  localparam int MAX_BAL_DEF = 999999;
  localparam int BCD_DIGITS  = 6;
  localparam int BCD_W       = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CONVERT,
    DONE
  } state_t;

  typedef enum logic {
    CREDIT,
    DEBIT
  } req_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// done is high during the cycle whose edge performs the final shift.
module bin2bcd_seq
  import balance_pkg::*;
#(
  parameter int BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   bin,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  localparam int SW = BCD_W + BITS;
  localparam int CW = $clog2(BITS + 1);

  logic [SW-1:0] sr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [SW-1:0] step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (t[BITS+4*d +: 4] >= 4'd5)
        t[BITS+4*d +: 4] = t[BITS+4*d +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sr_q  <= {{BCD_W{1'b0}}, bin};
      cnt_q <= CW'(BITS);
    end else if (cnt_q != '0) begin
      sr_q  <= step(sr_q);
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign bcd  = sr_q[SW-1 -: BCD_W];
endmodule

// File: rtl/balance_update_ctrl.sv
// Credit/debit balance controller with round-robin request arbitration,
// saturating credits, checked debits and a BCD mirror of the balance.
module balance_update_ctrl
  import balance_pkg::*;
#(
  parameter int MAX_BAL   = MAX_BAL_DEF,
  parameter int CONV_BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              credit_valid,
  input  logic [31:0]       credit_amt,
  output logic              credit_ready,
  input  logic              debit_valid,
  input  logic [31:0]       debit_amt,
  output logic              debit_ready,
  output logic              debit_ok,
  output logic              debit_fail,
  output logic [31:0]       balance,
  output logic [BCD_W-1:0]  bcd,
  output logic              bcd_valid,
  output logic              busy
);
  localparam logic [32:0] CEIL = 33'(MAX_BAL);

  state_t state_q, state_n;
  req_t   op_q, pref_q;

  logic [31:0]      amt_q, bal_q, nxt_bal;
  logic [32:0]      sum;
  logic [BCD_W-1:0] bcd_q, conv_bcd;
  logic             ok_q, fail_q;
  logic             idle, cr_gnt, db_gnt, xfer;
  logic             short_funds, conv_start, conv_done;

  assign idle   = (state_q == IDLE);
  assign cr_gnt = credit_valid &&
                  (!debit_valid || pref_q == CREDIT);
  assign db_gnt = debit_valid && !cr_gnt;

  assign credit_ready = idle && cr_gnt;
  assign debit_ready  = idle && db_gnt;
  assign xfer         = credit_ready || debit_ready;

  // 33-bit sum so a large credit saturates instead of wrapping
  assign sum         = {1'b0, bal_q} + {1'b0, amt_q};
  assign short_funds = (op_q == DEBIT) && (amt_q > bal_q);
  assign conv_start  = (state_q == APPLY) && !short_funds;

  always_comb begin
    nxt_bal = bal_q - amt_q;
    if (op_q == CREDIT)
      nxt_bal = (sum > CEIL) ? CEIL[31:0] : sum[31:0];
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (xfer) state_n = APPLY;
      APPLY:   state_n = short_funds ? IDLE : CONVERT;
      CONVERT: if (conv_done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= CREDIT;
      pref_q  <= CREDIT;
      amt_q   <= '0;
      bal_q   <= '0;
      bcd_q   <= '0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      if (xfer) begin
        op_q   <= credit_ready ? CREDIT : DEBIT;
        amt_q  <= credit_ready ? credit_amt : debit_amt;
        pref_q <= credit_ready ? DEBIT : CREDIT;
      end
      if (state_q == APPLY) begin
        if (short_funds) begin
          fail_q <= 1'b1;
        end else begin
          bal_q <= nxt_bal;
          ok_q  <= (op_q == DEBIT);
        end
      end
      if (state_q == DONE)
        bcd_q <= conv_bcd;
    end
  end

  // Converter is loaded with the post-update value at the APPLY edge
  bin2bcd_seq #(
    .BITS (CONV_BITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (nxt_bal[CONV_BITS-1:0]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // A rejected debit leaves the displayed digits valid
  always_comb begin
    bcd_valid = 1'b1;
    unique case (state_q)
      IDLE:    bcd_valid = 1'b1;
      APPLY:   bcd_valid = short_funds;
      CONVERT: bcd_valid = 1'b0;
      DONE:    bcd_valid = 1'b1;
      default: bcd_valid = 1'b1;
    endcase
  end

  assign bcd        = (state_q == DONE) ? conv_bcd : bcd_q;
  assign balance    = bal_q;
  assign debit_ok   = ok_q;
  assign debit_fail = fail_q;
  assign busy       = !idle;
endmodule

// File: tb/tb_balance_update_ctrl.sv
// Scoreboard bench for balance_update_ctrl.
// Expected results are queued at each handshake and retired on DUT output.
module tb_balance_update_ctrl;
  import balance_pkg::*;

  localparam int MAXB = 999999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        credit_valid = 1'b0;
  logic [31:0] credit_amt = '0;
  logic        credit_ready;
  logic        debit_valid = 1'b0;
  logic [31:0] debit_amt = '0;
  logic        debit_ready;
  logic        debit_ok, debit_fail;
  logic [31:0] balance;
  logic [23:0] bcd;
  logic        bcd_valid, busy;

  always #5 clk = ~clk;

  balance_update_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .credit_valid (credit_valid),
    .credit_amt   (credit_amt),
    .credit_ready (credit_ready),
    .debit_valid  (debit_valid),
    .debit_amt    (debit_amt),
    .debit_ready  (debit_ready),
    .debit_ok     (debit_ok),
    .debit_fail   (debit_fail),
    .balance      (balance),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid),
    .busy         (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          fail;
    logic [31:0] bal;
    logic [23:0] bcd;
  } exp_t;

  exp_t sb[$];
  exp_t e, p;
  bit   hs_log[$];

  logic [31:0] mbal = '0;
  longint      s;
  int n_fail = 0, n_ok = 0, n_low = 0;
  int low_run = 0, last_low = 0;
  int n_cr_hs = 0, n_db_hs = 0, rdy_busy = 0, hs_cyc = 0;
  logic prev_bv = 1'b1;

  function automatic logic [23:0] to_bcd(input logic [31:0] v);
    logic [23:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic retire(input bit was_fail);
    check("sb_nonempty", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_kind", 32'(was_fail), 32'(e.fail));
      check("sb_bal", balance, e.bal);
      if (!was_fail) check("sb_bcd", 32'(bcd), 32'(e.bcd));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mbal = '0;
      prev_bv = 1'b1;
      low_run = 0;
    end else begin
      if (credit_valid && credit_ready) begin
        n_cr_hs++;
        hs_cyc = cyc;
        hs_log.push_back(1'b0);
        s = longint'(mbal) + longint'(credit_amt);
        mbal = (s > MAXB) ? 32'(MAXB) : 32'(s);
        p.fail = 1'b0;
        p.bal = mbal;
        p.bcd = to_bcd(mbal);
        sb.push_back(p);
      end
      if (debit_valid && debit_ready) begin
        n_db_hs++;
        hs_cyc = cyc;
        hs_log.push_back(1'b1);
        p.fail = (debit_amt > mbal);
        if (!p.fail) mbal = mbal - debit_amt;
        p.bal = mbal;
        p.bcd = to_bcd(mbal);
        sb.push_back(p);
      end
      if ((credit_ready || debit_ready) && busy) rdy_busy++;
      if (debit_ok) n_ok++;
      if (debit_fail) begin
        n_fail++;
        retire(1'b1);
      end
      if (!bcd_valid) begin
        n_low++;
        low_run++;
      end
      if (bcd_valid && !prev_bv) begin
        last_low = low_run;
        low_run = 0;
        retire(1'b0);
      end
      prev_bv = bcd_valid;
    end
  end

  task automatic send(input bit is_debit, input logic [31:0] amt);
    bit got;
    got = 1'b0;
    if (is_debit) begin
      debit_valid = 1'b1;
      debit_amt = amt;
    end else begin
      credit_valid = 1'b1;
      credit_amt = amt;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_debit ? debit_ready : credit_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("hs_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    if (is_debit) debit_valid = 1'b0;
    else credit_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("idle_seen", 32'(!busy), 1);
  endtask

  int f0, l0, o0, c0, d0, cr_cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bal", balance, 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_bv", 32'(bcd_valid), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ok", 32'(debit_ok), 0);
    check("rst_fail", 32'(debit_fail), 0);
    rst = 1'b0;

    credit_valid = 1'b1;
    credit_amt = 32'd123456;
    #1;
    check("cr_rdy_now", 32'(credit_ready), 1);
    @(posedge clk);
    #1;
    credit_valid = 1'b0;
    check("apply_bv", 32'(bcd_valid), 0);
    check("apply_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    check("bal_post_apply", balance, 123456);
    repeat (21) @(posedge clk);
    #1;
    check("bcd_n23", 32'(bcd), 32'h123456);
    check("bv_n23", 32'(bcd_valid), 1);
    check("busy_n23", 32'(busy), 0);
    check("low_len", 32'(last_low), 21);

    f0 = n_fail;
    l0 = n_low;
    send(1'b1, 32'd200000);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("fail_pulses", 32'(n_fail - f0), 1);
    check("fail_bal", balance, 123456);
    check("fail_bv_low", 32'(n_low - l0), 0);

    send(1'b0, 32'd665556);
    wait_idle();
    check("bal_789012", balance, 789012);
    send(1'b0, 32'd500000);
    wait_idle();
    check("sat_bal", balance, 999999);
    check("sat_bcd", 32'(bcd), 32'h999999);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs_log.delete();
    o0 = n_ok;
    c0 = n_cr_hs;
    d0 = n_db_hs;
    credit_valid = 1'b1;
    credit_amt = 32'd10;
    debit_valid = 1'b1;
    debit_amt = 32'd5;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (n_cr_hs != c0) credit_valid = 1'b0;
      if (n_db_hs != d0) debit_valid = 1'b0;
      if (!credit_valid && !debit_valid) break;
    end
    check("both_served", 32'(credit_valid | debit_valid), 0);
    wait_idle();
    check("rr_count", 32'(hs_log.size()), 2);
    if (hs_log.size() >= 2) begin
      check("rr_first", 32'(hs_log[0]), 0);
      check("rr_second", 32'(hs_log[1]), 1);
    end
    check("rr_bal", balance, 5);
    check("rr_bcd", 32'(bcd), 32'h5);
    check("rr_ok", 32'(n_ok - o0), 1);

    send(1'b0, 32'd789012);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_bal", balance, 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_bv", 32'(bcd_valid), 1);
    check("abort_busy", 32'(busy), 0);

    d0 = n_db_hs;
    send(1'b0, 32'd100);
    cr_cyc = hs_cyc;
    debit_valid = 1'b1;
    debit_amt = 32'd30;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (n_db_hs != d0) break;
    end
    debit_valid = 1'b0;
    check("held_lat", 32'(hs_cyc - cr_cyc), 23);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("held_once", 32'(n_db_hs - d0), 1);
    check("rdy_busy", 32'(rdy_busy), 0);
    check("held_bal", balance, 70);
    check("held_bcd", 32'(bcd), 32'h70);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
